// File: rtl/axi_frame_buf_ctrl.sv
// Frame-buffer DMA controller: streams a write FIFO into DDR frames over AXI and
// reads the most recently completed frame back. Optional macro: AXI_RESP_CHECK_EN.
module axi_frame_buf_ctrl #(
   parameter int DATA_W      = 128,
   parameter int ADDR_W      = 28,
   parameter int BURST_LEN   = 16,
   parameter int FRAME_BYTES = 4147200,
   parameter int FRAME_NUM   = 3,
   parameter int BASE_ADDR   = 0
) (
   input  logic              ui_clk,
   input  logic              Rst_INIT_DONE,
   input  logic              wr_trigger,
   output logic              wfifo_rd_en,
   input  logic [DATA_W-1:0] wfifo_rd_data,
   input  logic              rd_trigger,
   output logic              rfifo_wr_en,
   output logic [DATA_W-1:0] rfifo_wr_data,
   output logic              wr_frame_done,
   output logic [1:0]        err,
   output logic [ADDR_W-1:0] m_axi_awaddr,
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,
   output logic [DATA_W-1:0] m_axi_wdata,
   output logic              m_axi_wlast,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,
   input  logic [1:0]        m_axi_bresp,
   input  logic              m_axi_bvalid,
   output logic              m_axi_bready,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic [DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rlast,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready
);

   localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;
   localparam int BEAT_W      = $clog2(BURST_LEN);
   localparam logic [ADDR_W-1:0] LAST_OFF   = ADDR_W'(FRAME_BYTES - BURST_BYTES);
   localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_BYTES);
   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {WS_IDLE = 2'd0, WS_AW = 2'd1, WS_W = 2'd2, WS_B = 2'd3} wr_state_t;
   typedef enum logic [1:0] {RS_IDLE = 2'd0, RS_AR = 2'd1, RS_R = 2'd2} rd_state_t;

   // Modular frame-index increment; fb < FRAME_NUM and step <= 2 keep one subtraction sufficient.
   function automatic logic [1:0] fb_add(input logic [1:0] fb, input logic [1:0] step);
      logic [2:0] sum;
      sum = {1'b0, fb} + {1'b0, step};
      if (sum >= 3'(FRAME_NUM)) begin
         sum = sum - 3'(FRAME_NUM);
      end else begin
         sum = sum;
      end
      return sum[1:0];
   endfunction

   function automatic logic [ADDR_W-1:0] frame_addr(input logic [1:0] fb, input logic [ADDR_W-1:0] off);
      return ADDR_W'(BASE_ADDR) + ADDR_W'(FRAME_BYTES) * {{(ADDR_W-2){1'b0}}, fb} + off;
   endfunction

   wr_state_t         wr_state_r, wr_state_nxt_s;
   rd_state_t         rd_state_r, rd_state_nxt_s;
   logic [ADDR_W-1:0] wr_off_r, rd_off_r;
   logic [1:0]        wr_fb_r, rd_fb_r, last_done_r;
   logic [1:0]        wr_fb_nxt_s, rd_fb_nxt_s, wr_fb_step1_s;
   logic [BEAT_W-1:0] beat_r;
   logic              wr_last_r, frame_done_r;
   logic              aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, wlast_s;

   assign m_axi_awvalid = (wr_state_r == WS_AW);
   assign m_axi_wvalid  = (wr_state_r == WS_W);
   assign m_axi_bready  = (wr_state_r == WS_B);
   assign m_axi_arvalid = (rd_state_r == RS_AR);
   assign m_axi_rready  = (rd_state_r == RS_R);

   assign aw_hs_s = m_axi_awvalid & m_axi_awready;
   assign w_hs_s  = m_axi_wvalid  & m_axi_wready;
   assign b_hs_s  = m_axi_bready  & m_axi_bvalid;
   assign ar_hs_s = m_axi_arvalid & m_axi_arready;
   assign r_hs_s  = m_axi_rvalid  & m_axi_rready;
   assign wlast_s = m_axi_wvalid & (beat_r == LAST_BEAT);

   assign m_axi_wlast   = wlast_s;
   assign m_axi_wdata   = wfifo_rd_data;
   assign wfifo_rd_en   = w_hs_s;
   assign rfifo_wr_en   = r_hs_s;
   assign rfifo_wr_data = m_axi_rdata;
   assign wr_frame_done = frame_done_r;

   // A burst at offset 0 reads the newest complete frame; later bursts stay on rd_fb.
   assign m_axi_awaddr = frame_addr(wr_fb_r, wr_off_r);
   assign m_axi_araddr = frame_addr((rd_off_r == '0) ? last_done_r : rd_fb_r, rd_off_r);

   // Write FSM next state.
   always_comb begin
      wr_state_nxt_s = wr_state_r;
      case (wr_state_r)
         WS_IDLE: if (wr_trigger) wr_state_nxt_s = WS_AW; else wr_state_nxt_s = WS_IDLE;
         WS_AW:   if (aw_hs_s) wr_state_nxt_s = WS_W; else wr_state_nxt_s = WS_AW;
         WS_W:    if (w_hs_s && wlast_s) wr_state_nxt_s = WS_B; else wr_state_nxt_s = WS_W;
         WS_B:    if (b_hs_s) wr_state_nxt_s = WS_IDLE; else wr_state_nxt_s = WS_B;
         default: wr_state_nxt_s = WS_IDLE;
      endcase
   end

   // Read FSM next state.
   always_comb begin
      rd_state_nxt_s = rd_state_r;
      case (rd_state_r)
         RS_IDLE: if (rd_trigger) rd_state_nxt_s = RS_AR; else rd_state_nxt_s = RS_IDLE;
         RS_AR:   if (ar_hs_s) rd_state_nxt_s = RS_R; else rd_state_nxt_s = RS_AR;
         RS_R:    if (r_hs_s && m_axi_rlast) rd_state_nxt_s = RS_IDLE; else rd_state_nxt_s = RS_R;
         default: rd_state_nxt_s = RS_IDLE;
      endcase
   end

   // Frame-index selection: the writer never lands on the frame the reader is about to hold.
   always_comb begin
      wr_fb_step1_s = fb_add(wr_fb_r, 2'd1);
      if (ar_hs_s && (rd_off_r == '0)) begin
         rd_fb_nxt_s = last_done_r;
      end else begin
         rd_fb_nxt_s = rd_fb_r;
      end
      if ((FRAME_NUM >= 3) && (wr_fb_step1_s == rd_fb_nxt_s)) begin
         wr_fb_nxt_s = fb_add(wr_fb_r, 2'd2);
      end else begin
         wr_fb_nxt_s = wr_fb_step1_s;
      end
   end

   // Write path state, offsets and frame bookkeeping.
   always_ff @(posedge ui_clk) begin
      if (!Rst_INIT_DONE) begin
         wr_state_r   <= WS_IDLE;
         wr_off_r     <= '0;
         wr_fb_r      <= 2'd0;
         last_done_r  <= 2'd0;
         beat_r       <= '0;
         wr_last_r    <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         wr_state_r   <= wr_state_nxt_s;
         frame_done_r <= b_hs_s & wr_last_r;
         if (aw_hs_s) begin
            wr_last_r <= (wr_off_r == LAST_OFF);
            wr_off_r  <= (wr_off_r == LAST_OFF) ? '0 : wr_off_r + BURST_STEP;
         end
         if (w_hs_s) begin
            beat_r <= wlast_s ? '0 : beat_r + BEAT_W'(1);
         end
         if (b_hs_s && wr_last_r) begin
            last_done_r <= wr_fb_r;
            wr_fb_r     <= wr_fb_nxt_s;
         end
      end
   end

   // Read path state and offsets.
   always_ff @(posedge ui_clk) begin
      if (!Rst_INIT_DONE) begin
         rd_state_r <= RS_IDLE;
         rd_off_r   <= '0;
         rd_fb_r    <= 2'd0;
      end else begin
         rd_state_r <= rd_state_nxt_s;
         rd_fb_r    <= rd_fb_nxt_s;
         if (ar_hs_s) begin
            rd_off_r <= (rd_off_r == LAST_OFF) ? '0 : rd_off_r + BURST_STEP;
         end
      end
   end

`ifdef AXI_RESP_CHECK_EN
   logic [1:0] err_r;

   // Sticky response errors: bit0 write response, bit1 read response.
   always_ff @(posedge ui_clk) begin
      if (!Rst_INIT_DONE) begin
         err_r <= 2'b00;
      end else begin
         if (b_hs_s && (m_axi_bresp != 2'b00)) err_r[0] <= 1'b1;
         if (r_hs_s && (m_axi_rresp != 2'b00)) err_r[1] <= 1'b1;
      end
   end

   assign err = err_r;
`else
   logic unused_resp_s;
   assign unused_resp_s = ^{m_axi_bresp, m_axi_rresp};
   assign err = 2'b00;
`endif

endmodule
